// File: rtl/alu_pkg.sv
// Shared ALU encodings and the issue-stage entry format.
// The ALU, the shifters and their benches import this package so that they all use the same encodings.
package alu_pkg;

    localparam int ALU_W = 32;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_SLL = 4'b1000;
    localparam logic [3:0] OP_SRL = 4'b1001;
    localparam logic [3:0] OP_SRA = 4'b1010;
    localparam logic [3:0] OP_NOR = 4'b1100;
    localparam logic [3:0] OP_XOR = 4'b1101;

    typedef struct packed {
        logic [ALU_W-1:0] x;
        logic [ALU_W-1:0] y;
        logic [3:0]       op;
        logic [4:0]       shamt;
        logic             oor;
        logic             illegal;
    } alu_entry_t;

    function automatic logic op_is_shift(input logic [3:0] op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

    function automatic logic op_is_legal(input logic [3:0] op);
        case (op)
            OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT,
            OP_NOR, OP_XOR, OP_SLL, OP_SRL, OP_SRA: return 1'b1;
            default:                                return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational pre-decode of an ALU opcode and its Y operand.
// It produces the shift amount, the out-of-range flag and the illegal-opcode flag.
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [3:0]       i_op,
    input  logic [ALU_W-1:0] i_y,
    output logic [4:0]       o_shamt,
    output logic             o_oor,
    output logic             o_illegal
);

    logic w_is_shift;

    assign w_is_shift = op_is_shift(i_op);
    assign o_shamt    = w_is_shift ? i_y[4:0] : 5'd0;
    // A shift by 32 or more leaves no source bits, so the shifter only needs this flag.
    assign o_oor      = w_is_shift & (|i_y[ALU_W-1:5]);
    assign o_illegal  = ~op_is_legal(i_op);

endmodule

// File: rtl/alu_issue_stage.sv
// Registered issue buffer in front of the ALU. It is a circular buffer of pre-decoded entries.
// Acceptance depends only on occupancy, never on the consumer's ready signal.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_x,
    input  logic [WIDTH-1:0]             in_y,
    input  logic [3:0]                   in_op,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_x,
    output logic [WIDTH-1:0]             out_y,
    output logic [3:0]                   out_op,
    output logic [4:0]                   out_shamt,
    output logic                         out_shift_oor,
    output logic                         out_illegal,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

    localparam int                PTR_W    = $clog2(DEPTH);
    localparam int                OCC_W    = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [OCC_W-1:0]  FULL_OCC = OCC_W'(DEPTH);

    alu_entry_t        r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [OCC_W-1:0]  r_occ;

    logic              w_push;
    logic              w_pop;
    logic [OCC_W-1:0]  w_occ_next;
    alu_entry_t        w_new;
    alu_entry_t        w_head;

    alu_op_decode u_decode (
        .i_op      (in_op),
        .i_y       (in_y),
        .o_shamt   (w_new.shamt),
        .o_oor     (w_new.oor),
        .o_illegal (w_new.illegal)
    );

    assign w_new.x  = in_x;
    assign w_new.y  = in_y;
    assign w_new.op = in_op;

    // When the buffer is full, a pop in the same cycle does not make room for a push.
    assign in_ready  = ~rst & (r_occ < FULL_OCC);
    assign out_valid = (r_occ != '0);
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;

    always_comb begin
        // NOTE: default first so every path assigns w_occ_next and no latch is inferred.
        w_occ_next = r_occ;
        case ({w_push, w_pop})
            2'b10:   w_occ_next = r_occ + 1'b1;
            2'b01:   w_occ_next = r_occ - 1'b1;
            default: w_occ_next = r_occ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
            // NOTE: storage is reset on purpose; the head drives outputs that must read 0, never X.
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_new;
                r_wr_ptr        <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
            end
            r_occ <= w_occ_next;
        end
    end

    assign w_head        = r_mem[r_rd_ptr];
    assign out_x         = w_head.x;
    assign out_y         = w_head.y;
    assign out_op        = w_head.op;
    assign out_shamt     = w_head.shamt;
    assign out_shift_oor = w_head.oor;
    assign out_illegal   = w_head.illegal;
    assign occupancy     = r_occ;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed self-checking bench for alu_issue_stage with DEPTH=2.
// The expected values are constants worked out by hand from the stage's behaviour.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_x;
    logic [31:0] in_y;
    logic [3:0]  in_op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_x;
    logic [31:0] out_y;
    logic [3:0]  out_op;
    logic [4:0]  out_shamt;
    logic        out_shift_oor;
    logic        out_illegal;
    logic [1:0]  occupancy;

    int checks = 0;
    int errors = 0;

    alu_issue_stage #(.DEPTH(2), .WIDTH(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_x          (in_x),
        .in_y          (in_y),
        .in_op         (in_op),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_x         (out_x),
        .out_y         (out_y),
        .out_op        (out_op),
        .out_shamt     (out_shamt),
        .out_shift_oor (out_shift_oor),
        .out_illegal   (out_illegal),
        .occupancy     (occupancy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // The bench samples #1 after the rising edge and drives new inputs at that same point.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] x, input logic [31:0] y, input logic [3:0] op);
        in_valid = v;
        in_x     = x;
        in_y     = y;
        in_op    = op;
    endtask

    initial begin
        rst       = 1'b1;
        out_ready = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 4'h0);
        tick();
        tick();
        check("rst_in_ready",  32'(in_ready),  32'd0);
        check("rst_occ",       32'(occupancy), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_x",     out_x,          32'd0);
        check("rst_out_y",     out_y,          32'd0);
        check("rst_flags",     32'({out_op, out_shamt, out_shift_oor, out_illegal}), 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Single SLL with the consumer ready
        out_ready = 1'b1;
        drive(1'b1, 32'h0000_0001, 32'd5, 4'b1000);
        tick();
        drive(1'b0, 32'h0, 32'h0, 4'h0);
        check("sll_valid",   32'(out_valid),     32'd1);
        check("sll_x",       out_x,              32'h1);
        check("sll_shamt",   32'(out_shamt),     32'd5);
        check("sll_oor",     32'(out_shift_oor), 32'd0);
        check("sll_illegal", 32'(out_illegal),   32'd0);
        check("sll_occ",     32'(occupancy),     32'd1);
        tick();
        check("sll_drain_occ",   32'(occupancy), 32'd0);
        check("sll_drain_valid", 32'(out_valid), 32'd0);

        // Out-of-range SRL
        out_ready = 1'b0;
        drive(1'b1, 32'h0000_00AA, 32'h0000_0020, 4'b1001);
        tick();
        drive(1'b0, 32'h0, 32'h0, 4'h0);
        check("srl_oor_shamt", 32'(out_shamt),     32'd0);
        check("srl_oor_flag",  32'(out_shift_oor), 32'd1);
        check("srl_oor_y",     out_y,              32'h20);
        check("srl_oor_ill",   32'(out_illegal),   32'd0);
        out_ready = 1'b1;
        tick();
        check("srl_oor_drain", 32'(occupancy), 32'd0);

        // Backpressure: the third push is held off until there is room
        out_ready = 1'b0;
        drive(1'b1, 32'h100, 32'h0, 4'b0010);
        tick();
        check("bp_occ1",   32'(occupancy), 32'd1);
        check("bp_rdy1",   32'(in_ready),  32'd1);
        drive(1'b1, 32'h101, 32'h0, 4'b0010);
        tick();
        check("bp_occ2",   32'(occupancy), 32'd2);
        check("bp_rdy2",   32'(in_ready),  32'd0);
        drive(1'b1, 32'h102, 32'h0, 4'b0010);
        tick();
        check("bp_held_occ",  32'(occupancy), 32'd2);
        check("bp_held_head", out_x,          32'h100);

        // Full with simultaneous pop: the pop completes and the push is refused
        out_ready = 1'b1;
        #1;
        check("full_pop_rdy", 32'(in_ready), 32'd0);
        tick();
        check("full_pop_occ",  32'(occupancy), 32'd1);
        check("full_pop_head", out_x,          32'h101);
        tick();
        check("third_occ",  32'(occupancy), 32'd1);
        check("third_head", out_x,          32'h102);

        // Stream six items at full rate; the pointers wrap repeatedly
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 32'h200 + 32'(i), 32'(i), 4'b0000);
            tick();
            check($sformatf("stream_x%0d", i),   out_x,          32'h200 + 32'(i));
            check($sformatf("stream_occ%0d", i), 32'(occupancy), 32'd1);
        end
        drive(1'b0, 32'h0, 32'h0, 4'h0);
        tick();
        check("stream_drain_valid", 32'(out_valid), 32'd0);

        // Illegal opcode with all-ones Y, held under backpressure
        out_ready = 1'b0;
        drive(1'b1, 32'h5, 32'hFFFF_FFFF, 4'b0011);
        tick();
        drive(1'b0, 32'h0, 32'h0, 4'h0);
        check("ill_flag",  32'(out_illegal),   32'd1);
        check("ill_shamt", 32'(out_shamt),     32'd0);
        check("ill_oor",   32'(out_shift_oor), 32'd0);
        check("ill_op",    32'(out_op),        32'h3);
        tick();
        check("ill_stable_x",     out_x,          32'h5);
        check("ill_stable_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        tick();

        // ADD with a nonzero Y, then a legal in-range SRA
        drive(1'b1, 32'h9, 32'd7, 4'b0010);
        tick();
        check("add_shamt", 32'(out_shamt),   32'd0);
        check("add_ill",   32'(out_illegal), 32'd0);
        check("add_op",    32'(out_op),      32'h2);
        drive(1'b1, 32'h8000_0000, 32'h0000_001F, 4'b1010);
        tick();
        drive(1'b0, 32'h0, 32'h0, 4'h0);
        check("sra_shamt", 32'(out_shamt),     32'd31);
        check("sra_oor",   32'(out_shift_oor), 32'd0);
        check("sra_ill",   32'(out_illegal),   32'd0);
        tick();

        // Reset while full discards both entries
        out_ready = 1'b0;
        drive(1'b1, 32'h300, 32'h0, 4'b0001);
        tick();
        drive(1'b1, 32'h301, 32'h0, 4'b0001);
        tick();
        check("mid_full_occ", 32'(occupancy), 32'd2);
        rst       = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, 32'h302, 32'h0, 4'b0001);
        #1;
        check("mid_rst_rdy", 32'(in_ready), 32'd0);
        tick();
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_occ",   32'(occupancy), 32'd0);
        check("mid_rst_x",     out_x,          32'd0);
        rst = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 4'h0);
        tick();
        check("no_stale_valid", 32'(out_valid), 32'd0);
        drive(1'b1, 32'h400, 32'h0, 4'b1101);
        tick();
        drive(1'b0, 32'h0, 32'h0, 4'h0);
        check("fresh_x",     out_x,          32'h400);
        check("fresh_valid", 32'(out_valid), 32'd1);
        tick();
        check("fresh_drain", 32'(occupancy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
